mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 42 ++++
 rtl/mem_byte_array.sv | 24 ++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// ============================================================================
// mem_responder_pkg : shared encodings and helpers for mem_responder | Rev 1.0
// ============================================================================
`default_nettype none

package mem_responder_pkg;

  localparam logic [1:0] c_TD_BYTE = 2'b00;
  localparam logic [1:0] c_TD_HALF = 2'b01;
  localparam logic [1:0] c_TD_WORD = 2'b10;

  localparam logic c_RW_READ  = 1'b1;
  localparam logic c_RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index of the final byte for a transfer size (11 behaves as a word).
  function automatic logic [1:0] last_idx(input logic [1:0] td);
    case (td)
      c_TD_BYTE: last_idx = 2'd0;
      c_TD_HALF: last_idx = 2'd1;
      default:   last_idx = 2'd3;
    endcase
  endfunction

  // Left-justify write data so the first byte sent always sits in [31:24].
  function automatic logic [31:0] align_msb(input logic [1:0] td, input logic [31:0] d);
    case (td)
      c_TD_BYTE: align_msb = {d[7:0], 24'h0};
      c_TD_HALF: align_msb = {d[15:0], 16'h0};
      default:   align_msb = d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_array.sv
// ============================================================================
// mem_byte_array : 256x8 storage, synchronous write, combinational read | Rev 1.0
// ============================================================================
`default_nettype none

module mem_byte_array (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);

  logic [7:0] mem [0:255];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : byte-serial big-endian memory responder with access latency | Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC
);

  localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_xfer_we;
  logic        w_mem_we;
  logic [7:0]  w_rbyte;
  logic        w_unused;

  logic [7:0]  r_addr;
  logic        r_rw;
  logic [31:0] r_wdata;
  logic [23:0] r_asm;
  logic [31:0] r_dout;
  logic [3:0]  r_wcnt;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  logic        r_moc;

  assign w_unused = ^Address[31:8];

  always_ff @(posedge CLK) begin
    if (CLR) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_xfer_we = 1'b0;
    case (r_state)
      ST_IDLE: if (MOV) w_next = (WAIT_CYCLES == 0) ? ST_XFER : ST_WAIT;
      ST_WAIT: if (r_wcnt == c_WAIT_LAST) w_next = ST_XFER;
      ST_XFER: begin
        w_xfer_we = (r_rw == c_RW_WRITE);
        if (r_idx == r_last) w_next = ST_DONE;
      end
      ST_DONE: if (!MOV) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // A reset edge landing in XFER must not commit the byte in flight.
  assign w_mem_we = w_xfer_we & ~CLR;

  mem_byte_array u_mem (
    .i_clk   (CLK),
    .i_we    (w_mem_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata[31:24]),
    .o_rdata (w_rbyte)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_addr  <= 8'h0;
      r_rw    <= 1'b0;
      r_wdata <= 32'h0;
      r_asm   <= 24'h0;
      r_dout  <= 32'h0;
      r_wcnt  <= 4'h0;
      r_idx   <= 2'h0;
      r_last  <= 2'h0;
      r_moc   <= 1'b0;
    end else begin
      r_moc <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: if (MOV) begin
          r_addr  <= Address[7:0];
          r_rw    <= RW;
          r_wdata <= align_msb(typeData, DataIn);
          r_last  <= last_idx(typeData);
          r_asm   <= 24'h0;
          r_wcnt  <= 4'h0;
          r_idx   <= 2'h0;
        end
        ST_WAIT: r_wcnt <= r_wcnt + 4'd1;
        ST_XFER: begin
          r_addr  <= r_addr + 8'd1;
          r_idx   <= r_idx + 2'd1;
          r_wdata <= {r_wdata[23:0], 8'h0};
          if (r_rw == c_RW_READ) begin
            r_asm <= {r_asm[15:0], w_rbyte};
            if (r_idx == r_last) r_dout <= {r_asm, w_rbyte};
          end
        end
        default: ;
      endcase
    end
  end

  assign DataOut = r_dout;
  assign MOC     = r_moc;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : scoreboard bench for mem_responder (WAIT=2 and WAIT=0) | Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mov0 = 1'b0, mov1 = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  td = 2'b00;
  logic [31:0] addr = 32'h0, din = 32'h0;
  logic [31:0] dout0, dout1;
  logic        moc0, moc1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic pm0 = 1'b0, pm1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.WAIT_CYCLES(2)) u0 (
    .CLK(clk), .CLR(clr), .MOV(mov0), .RW(rw), .typeData(td),
    .Address(addr), .DataIn(din), .DataOut(dout0), .MOC(moc0)
  );

  mem_responder #(.WAIT_CYCLES(0)) u1 (
    .CLK(clk), .CLR(clr), .MOV(mov1), .RW(rw), .typeData(td),
    .Address(addr), .DataIn(din), .DataOut(dout1), .MOC(moc1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard monitors: each MOC rising edge pops one expectation.
  always @(negedge clk) begin
    if (moc0 && !pm0) begin
      if (q0.size() == 0) chk("unexpected_moc0", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("lat0", 32'(cyc), 32'(e0.cyc));
        chk("data0", dout0, e0.data);
      end
    end
    pm0 <= moc0;
  end

  always @(negedge clk) begin
    if (moc1 && !pm1) begin
      if (q1.size() == 0) chk("unexpected_moc1", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("lat1", 32'(cyc), 32'(e1.cyc));
        chk("data1", dout1, e1.data);
      end
    end
    pm1 <= moc1;
  end

  function automatic int nbytes(input logic [1:0] t);
    return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
  endfunction

  // Full handshake on u0: hold MOV until MOC, keep it `hold` extra cycles, then drop.
  task automatic req0(input logic r, input logic [1:0] t, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] exp, input int hold);
    int n;
    n = nbytes(t);
    @(negedge clk);
    rw = r; td = t; addr = {24'hABCDEF, a}; din = d; mov0 = 1'b1;
    q0.push_back('{cyc + 1 + 2 + n, exp});
    for (int i = 0; i < 40 && !moc0; i++) @(negedge clk);
    if (!moc0) chk("timeout_moc0", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("moc_hold", {31'h0, moc0}, 32'd1);
    end
    mov0 = 1'b0;
    rw = ~r; td = 2'b10; addr = 32'h0; din = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("moc_clear", {31'h0, moc0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    chk("rst_moc0", {31'h0, moc0}, 32'd0);
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_moc1", {31'h0, moc1}, 32'd0);
    chk("rst_dout1", dout1, 32'h0);

    u0.u_mem.mem[4] = 8'hDE; u0.u_mem.mem[5] = 8'hAD;
    u0.u_mem.mem[6] = 8'hBE; u0.u_mem.mem[7] = 8'hEF;
    u0.u_mem.mem[8'h20] = 8'hAA; u0.u_mem.mem[8'h21] = 8'hBB;
    u0.u_mem.mem[8'h22] = 8'hCC; u0.u_mem.mem[8'h23] = 8'hDD;
    u1.u_mem.mem[8'h10] = 8'hA5;

    // Word read, big-endian assembly.
    req0(1'b1, 2'b10, 8'h04, 32'h0, 32'hDEADBEEF, 0);

    // Halfword write across the 0xFF/0x00 wrap; DataOut must not move.
    req0(1'b0, 2'b01, 8'hFF, 32'hCAFE_1234, 32'hDEADBEEF, 0);
    chk("mem_ff", {24'h0, u0.u_mem.mem[8'hFF]}, 32'h12);
    chk("mem_00", {24'h0, u0.u_mem.mem[8'h00]}, 32'h34);
    req0(1'b1, 2'b00, 8'hFF, 32'h0, 32'h0000_0012, 0);
    req0(1'b1, 2'b00, 8'h00, 32'h0, 32'h0000_0034, 0);

    // Zero-wait byte read on the second instance.
    @(negedge clk);
    rw = 1'b1; td = 2'b00; addr = 32'h0000_0010; din = 32'h0; mov1 = 1'b1;
    q1.push_back('{cyc + 1 + 0 + 1, 32'h0000_00A5});
    for (int i = 0; i < 40 && !moc1; i++) @(negedge clk);
    if (!moc1) chk("timeout_moc1", 32'd0, 32'd1);
    mov1 = 1'b0;
    @(negedge clk);
    chk("moc1_clear", {31'h0, moc1}, 32'd0);

    // MOV held past MOC, then a fresh request; typeData 11 acts as word.
    req0(1'b1, 2'b11, 8'h04, 32'h0, 32'hDEADBEEF, 5);
    req0(1'b1, 2'b01, 8'h05, 32'h0, 32'h0000_ADBE, 0);

    // One-cycle MOV pulse: transaction completes, MOC lasts a single cycle.
    @(negedge clk);
    rw = 1'b1; td = 2'b00; addr = 32'h0000_0006; mov0 = 1'b1;
    q0.push_back('{cyc + 1 + 2 + 1, 32'h0000_00BE});
    @(negedge clk);
    mov0 = 1'b0; rw = 1'b0; td = 2'b10; addr = 32'h0000_0080;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (moc0) hi++;
    end
    chk("pulse_moc_cycles", 32'(hi), 32'd1);

    // Word write interrupted by reset after two bytes have been stored.
    @(negedge clk);
    rw = 1'b0; td = 2'b10; addr = 32'h0000_0020; din = 32'h1122_3344; mov0 = 1'b1;
    repeat (5) @(negedge clk);
    clr = 1'b1; mov0 = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_mem20", {24'h0, u0.u_mem.mem[8'h20]}, 32'h11);
    chk("clr_mem21", {24'h0, u0.u_mem.mem[8'h21]}, 32'h22);
    chk("clr_mem22", {24'h0, u0.u_mem.mem[8'h22]}, 32'hCC);
    chk("clr_mem23", {24'h0, u0.u_mem.mem[8'h23]}, 32'hDD);
    chk("clr_moc", {31'h0, moc0}, 32'd0);
    chk("clr_dout", dout0, 32'h0);
    chk("clr_mem04", {24'h0, u0.u_mem.mem[4]}, 32'hDE);

    // After reset the responder accepts again.
    req0(1'b1, 2'b10, 8'h20, 32'h0, 32'hAABB_CCDD & 32'h0 | 32'h1122_CCDD, 0);

    repeat (4) @(negedge clk);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
